// File: rtl/sa48_serial_adder.sv
// ---------------------------------------------------------------------------
// sa48_serial_adder
//
// Purpose:
//   Serial adder for 48-bit operands that arrive over 12-bit buses. Each
//   operand comes in as NUM_CHUNKS chunks, least-significant chunk first,
//   one chunk pair per clock. Every chunk pair is added together with the
//   carry from the previous chunk. The chunk sums are collected in a right-
//   shifting result register, and a ready flag is raised once the full sum
//   is in place. The sum wraps modulo 2^(CHUNK_W*NUM_CHUNKS); the carry out
//   of the final chunk is dropped.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   inBusA       operand A chunk, sampled on each ADD edge
//   inBusB       operand B chunk, sampled on each ADD edge
//   startChunks  start request, honoured only in IDLE or DONE
//   outBus       result shift register; valid only while resultReady=1
//   resultReady  high while outBus holds a completed sum
// ---------------------------------------------------------------------------
module sa48_serial_adder #(
    parameter int CHUNK_W    = 12,
    parameter int NUM_CHUNKS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHUNK_W-1:0]            inBusA,
    input  logic [CHUNK_W-1:0]            inBusB,
    input  logic                          startChunks,
    output logic [CHUNK_W*NUM_CHUNKS-1:0] outBus,
    output logic                          resultReady
);

    localparam int RES_W = CHUNK_W * NUM_CHUNKS;
    localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        ADD,
        DONE
    } state_t;

    state_t             state;
    logic               carry;
    logic [CNT_W-1:0]   chunkCount;
    logic [CHUNK_W:0]   chunkSum;   // {carry out, chunk sum}

    // This is the chunk adder. It is one bit wider than a chunk, so its MSB
    // is the carry into the next chunk.
    // NOTE: every signal assigned in always_comb gets a value on every
    // path, so no latch is inferred.
    always_comb begin
        chunkSum = {1'b0, inBusA} + {1'b0, inBusB} + {{CHUNK_W{1'b0}}, carry};
    end

    // This single always_ff holds both the control FSM and the datapath.
    // All outputs are registered.
    // NOTE: use non-blocking assignments here. Every register then sees
    // the values from before the edge, which makes the carry and the shift
    // register update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            carry       <= 1'b0;
            chunkCount  <= '0;
            outBus      <= '0;
            resultReady <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (startChunks) state <= INIT;
                end

                INIT: begin
                    carry       <= 1'b0;
                    chunkCount  <= '0;
                    outBus      <= '0;
                    resultReady <= 1'b0;
                    state       <= ADD;
                end

                ADD: begin
                    // The new chunk sum enters at the top and older chunks
                    // shift right. After the last chunk, chunk 0's sum sits
                    // in the lowest bits.
                    carry      <= chunkSum[CHUNK_W];
                    outBus     <= {chunkSum[CHUNK_W-1:0], outBus[RES_W-1:CHUNK_W]};
                    chunkCount <= chunkCount + 1'b1;
                    if (chunkCount == LAST_CHUNK) begin
                        resultReady <= 1'b1;
                        state       <= DONE;
                    end
                end

                DONE: begin
                    // The result holds until a new start arrives. INIT then
                    // clears it on the following edge.
                    if (startChunks) state <= INIT;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sa48_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_sa48_serial_adder
//
// Self-checking bench for sa48_serial_adder. The driver issues operations.
// For each one it pushes the expected 48-bit sum, computed as (A + B) mod
// 2^48, and the cycle at which the sum must appear. A separate monitor waits
// for each rising resultReady, pops the oldest expectation and compares the
// sum and its arrival cycle.
// ---------------------------------------------------------------------------
module tb_sa48_serial_adder;

    localparam int CW = 12;
    localparam int NC = 4;
    localparam int RW = CW * NC;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] inBusA;
    logic [CW-1:0] inBusB;
    logic          startChunks;
    logic [RW-1:0] outBus;
    logic          resultReady;

    sa48_serial_adder #(.CHUNK_W(CW), .NUM_CHUNKS(NC)) dut (
        .clk         (clk),
        .rst         (rst),
        .inBusA      (inBusA),
        .inBusB      (inBusB),
        .startChunks (startChunks),
        .outBus      (outBus),
        .resultReady (resultReady)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [RW-1:0] sum;
        int            readyCyc;
        string         name;
    } exp_t;

    exp_t expQ[$];
    int   nTests = 0;
    int   nFail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        nTests++;
        if (act !== req) begin
            nFail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic prevReady = 1'b0;
    exp_t monE;
    always @(negedge clk) begin
        if (resultReady === 1'b1 && prevReady !== 1'b1) begin
            if (expQ.size() == 0) begin
                check("unexpected resultReady", 64'd1, 64'd0);
            end else begin
                monE = expQ.pop_front();
                check({monE.name, " sum"}, 64'(outBus), 64'(monE.sum));
                check({monE.name, " latency"}, 64'(cyc), 64'(monE.readyCyc));
            end
        end
        prevReady = resultReady;
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RW-1:0] rand48();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[RW-1:0];
    endfunction

    // Runs one complete operation. The start is sampled at edge E0, INIT
    // runs at E1, and chunks are sampled at E2..E5. The sum must then be
    // visible 5 cycles after E0.
    task automatic runOp(input string name, input logic [RW-1:0] a, input logic [RW-1:0] b,
                         input bit pulseInAdd);
        int            startCyc;
        logic [RW-1:0] modelSum;
        modelSum    = a + b;
        startChunks = 1'b1;
        tick();                                  // E0
        startCyc    = cyc;
        expQ.push_back('{modelSum, startCyc + 5, name});
        startChunks = 1'b0;
        inBusA      = CW'($urandom);             // INIT ignores the inputs
        inBusB      = CW'($urandom);
        tick();                                  // E1: INIT
        check({name, " init ready"}, 64'(resultReady), 64'd0);
        check({name, " init clear"}, 64'(outBus), 64'd0);
        for (int k = 0; k < NC; k++) begin
            inBusA      = a[k*CW +: CW];
            inBusB      = b[k*CW +: CW];
            startChunks = pulseInAdd && (k == 1);
            tick();                              // E2..E5
            if (k < NC - 1) check({name, " add ready"}, 64'(resultReady), 64'd0);
        end
        startChunks = 1'b0;
    endtask

    logic [RW-1:0] ra, rb;

    initial begin
        rst         = 1'b1;
        startChunks = 1'b0;
        inBusA      = '0;
        inBusB      = '0;

        // Reset, then idle with no start request.
        tick();
        tick();
        check("reset outBus", 64'(outBus), 64'd0);
        check("reset ready", 64'(resultReady), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            inBusA = CW'($urandom);
            inBusB = CW'($urandom);
            tick();
        end
        check("idle ready", 64'(resultReady), 64'd0);
        check("idle outBus", 64'(outBus), 64'd0);

        // Carry chain, followed by a hold in DONE.
        runOp("carry chain", {12'hFFF, 12'hFFA, 12'h000, 12'h003},
                             {12'hFFF, 12'hFFB, 12'h001, 12'h004}, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        check("carry chain hold sum", 64'(outBus), 64'h0000_FFFF_F500_1007);
        check("carry chain hold ready", 64'(resultReady), 64'd1);

        // Wrap-around, started straight out of DONE.
        runOp("wrap", {12'h000, 12'h00D, 12'h000, 12'h003},
                      {12'hFFF, 12'hFFB, 12'h001, 12'h005}, 1'b0);
        tick();
        check("wrap const sum", 64'(outBus), 64'h0000_0000_0800_1008);

        // Back-to-back: the next start arrives in the first DONE cycle.
        runOp("b2b first", rand48(), rand48(), 1'b0);
        runOp("b2b second", rand48(), rand48(), 1'b0);

        // Reset mid-ADD, with the carry register set when reset hits.
        startChunks = 1'b1;
        tick();
        startChunks = 1'b0;
        tick();                                  // INIT
        inBusA = 12'h001; inBusB = 12'h002;
        tick();                                  // chunk 0
        inBusA = 12'hFFF; inBusB = 12'h001;
        tick();                                  // chunk 1 -> carry = 1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset outBus", 64'(outBus), 64'd0);
        check("midreset ready", 64'(resultReady), 64'd0);
        for (int i = 0; i < 3; i++) tick();
        check("midreset idle ready", 64'(resultReady), 64'd0);
        runOp("after reset", {12'h123, 12'h456, 12'h789, 12'h000},
                             {12'h111, 12'h222, 12'h333, 12'h000}, 1'b0);
        tick();

        // A start during ADD is ignored.
        runOp("ignored start", rand48(), rand48(), 1'b1);
        tick();
        tick();

        // All ones plus one wraps to zero.
        runOp("all ones", 48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001, 1'b0);

        // Random operations with random gaps (0 = start directly from DONE).
        for (int n = 0; n < 30; n++) begin
            ra = rand48();
            rb = rand48();
            if (n % 5 == 0) rb = ~ra;            // long carry propagation
            runOp("random", ra, rb, ($urandom_range(0, 3) == 0));
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        end

        // Drain the scoreboard, with a bound on the wait.
        for (int i = 0; i < 20 && expQ.size() != 0; i++) tick();
        check("scoreboard drain", 64'(expQ.size()), 64'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
